laser_nibble_tx: RTL and testbench



---
 rtl/laser_nibble_tx.sv | 96 +++++++++
 tb/tb_laser_nibble_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/laser_nibble_tx.sv
// laser_nibble_tx: buffers a packet via valid/ready, then sends it as a framed nibble burst on 4 lanes
// Ports: clock/resetN (async active-low), data_in/data_in_valid/data_in_ready byte handshake,
// lanes registered lane symbol, tx_active high for the whole frame, pkt_sent pulse on the final gap cycle.
module laser_nibble_tx #(
  parameter int PKT_BYTES     = 4,
  parameter int CLKS_PER_SYM  = 4,
  parameter int PREAMBLE_SYMS = 8,
  parameter int GAP_SYMS      = 4
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [3:0] lanes,
  output logic       tx_active,
  output logic       pkt_sent
);
  localparam int S1   = PREAMBLE_SYMS > 2 * PKT_BYTES ? PREAMBLE_SYMS : 2 * PKT_BYTES;
  localparam int SMAX = S1 > GAP_SYMS ? S1 : GAP_SYMS;
  localparam int SW   = SMAX > 1 ? $clog2(SMAX) : 1;
  localparam int CW   = PKT_BYTES > 1 ? $clog2(PKT_BYTES) : 1;
  localparam int YW   = CLKS_PER_SYM > 1 ? $clog2(CLKS_PER_SYM) : 1;
  typedef enum logic [2:0] {FILL, PRE, SYNC, DATA, CHECK, GAP} state_t;
  state_t          r_state, w_state_n;
  logic [SW-1:0]   r_sym, w_sym_n, w_last_sym;
  logic [YW-1:0]   r_cyc, w_cyc_n;
  logic [CW-1:0]   r_cnt, w_bidx;
  logic [7:0]      r_chk, w_byte;
  logic [7:0]      r_buf [PKT_BYTES];
  logic [3:0]      r_lanes, w_lanes_n;
  logic            w_acc, w_sym_end, w_last;
  assign data_in_ready = r_state == FILL && resetN;
  assign w_acc         = data_in_valid && data_in_ready;
  assign tx_active     = r_state != FILL;
  assign lanes         = r_lanes;
  assign w_last_sym    = r_state == PRE   ? SW'(PREAMBLE_SYMS - 1) :
                         r_state == DATA  ? SW'(2 * PKT_BYTES - 1) :
                         r_state == CHECK ? SW'(1) :
                         r_state == GAP   ? SW'(GAP_SYMS - 1) : '0;
  assign w_sym_end     = r_cyc == YW'(CLKS_PER_SYM - 1);
  assign w_last        = w_sym_end && r_sym == w_last_sym;
  assign pkt_sent      = r_state == GAP && w_last;
  always_comb begin
    w_state_n = r_state;
    w_sym_n   = r_sym;
    w_cyc_n   = r_cyc;
    if (r_state == FILL) begin
      if (w_acc && r_cnt == CW'(PKT_BYTES - 1)) w_state_n = PRE;
    end else if (!w_sym_end) begin
      w_cyc_n = r_cyc + 1'b1;
    end else begin
      w_cyc_n = '0;
      w_sym_n = w_last ? '0 : r_sym + 1'b1;
      if (w_last)
        case (r_state)
          PRE:     w_state_n = SYNC;
          SYNC:    w_state_n = DATA;
          DATA:    w_state_n = CHECK;
          CHECK:   w_state_n = GAP;
          default: w_state_n = FILL;
        endcase
    end
  end
  // lanes is registered, so the symbol is chosen from the state/symbol about to be entered
  assign w_bidx    = CW'(w_sym_n >> 1);
  assign w_byte    = r_buf[w_bidx];
  assign w_lanes_n = w_state_n == PRE   ? (w_sym_n[0] ? 4'h5 : 4'hA) :
                     w_state_n == SYNC  ? 4'hF :
                     w_state_n == DATA  ? (w_sym_n[0] ? w_byte[3:0] : w_byte[7:4]) :
                     w_state_n == CHECK ? (w_sym_n[0] ? r_chk[3:0] : r_chk[7:4]) : 4'h0;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= FILL;
      r_sym   <= '0;
      r_cyc   <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_lanes <= 4'h0;
    end else begin
      r_state <= w_state_n;
      r_sym   <= w_sym_n;
      r_cyc   <= w_cyc_n;
      r_lanes <= w_lanes_n;
      if (w_acc) begin
        r_chk <= r_chk ^ data_in;
        r_cnt <= r_cnt == CW'(PKT_BYTES - 1) ? '0 : r_cnt + 1'b1;
      end else if (pkt_sent) begin
        r_chk <= '0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (w_acc) r_buf[r_cnt] <= data_in;
  end
endmodule

// File: tb/tb_laser_nibble_tx.sv
// tb_laser_nibble_tx: random and directed checks of two laser_nibble_tx instances against a frame-level model
module tb_laser_nibble_tx;
  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic [3:0] ln  [2];
  logic       rdy [2];
  logic       act [2];
  logic       snt [2];
  int         n_err = 0;
  int         n_chk = 0;
  logic [4:0] fr [2][0:127];
  int         fl [2] = '{0, 0};
  int         fp [2] = '{0, 0};
  logic [7:0] by [2][0:3];
  int         nb [2] = '{0, 0};
  int         act_cnt [2] = '{0, 0};
  int         sent_cnt [2] = '{0, 0};
  logic       acc0;
  always #5 clock = ~clock;
  laser_nibble_tx dut0 (
    .clock(clock), .resetN(resetN), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(rdy[0]), .lanes(ln[0]), .tx_active(act[0]), .pkt_sent(snt[0])
  );
  laser_nibble_tx #(.PKT_BYTES(1), .CLKS_PER_SYM(1)) dut1 (
    .clock(clock), .resetN(resetN), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(rdy[1]), .lanes(ln[1]), .tx_active(act[1]), .pkt_sent(snt[1])
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic build(input int k);
    int pk  = k ? 1 : 4;
    int cps = k ? 1 : 4;
    logic [7:0] c = 8'h00;
    logic [3:0] s [$];
    for (int i = 0; i < 8; i++) s.push_back(i % 2 ? 4'h5 : 4'hA);
    s.push_back(4'hF);
    for (int i = 0; i < pk; i++) begin
      c ^= by[k][i];
      s.push_back(by[k][i][7:4]);
      s.push_back(by[k][i][3:0]);
    end
    s.push_back(c[7:4]);
    s.push_back(c[3:0]);
    for (int i = 0; i < 4; i++) s.push_back(4'h0);
    fl[k] = 0;
    foreach (s[i]) repeat (cps) begin
      fr[k][fl[k]] = {1'b0, s[i]};
      fl[k]++;
    end
    fr[k][fl[k]-1][4] = 1'b1;
    fp[k] = 0;
  endtask
  task automatic rst_model();
    for (int k = 0; k < 2; k++) begin
      fl[k] = 0;
      fp[k] = 0;
      nb[k] = 0;
    end
  endtask
  task automatic tick(input logic v, input logic [7:0] d);
    data_in_valid = v;
    data_in = d;
    acc0 = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      logic in_f;
      logic acc;
      in_f = fp[k] < fl[k];
      check($sformatf("lanes%0d", k), ln[k], in_f ? fr[k][fp[k]][3:0] : 4'h0);
      check($sformatf("tx_active%0d", k), act[k], in_f);
      check($sformatf("pkt_sent%0d", k), snt[k], in_f ? fr[k][fp[k]][4] : 1'b0);
      check($sformatf("ready%0d", k), rdy[k], !in_f && resetN);
      act_cnt[k] += act[k];
      sent_cnt[k] += snt[k];
      acc = v && !in_f && resetN;
      if (in_f) fp[k]++;
      if (acc) begin
        by[k][nb[k]] = d;
        nb[k]++;
        if (nb[k] == (k ? 1 : 4)) begin
          build(k);
          nb[k] = 0;
        end
      end
      if (k == 0) acc0 = acc;
    end
    @(posedge clock);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while ((fp[0] < fl[0] || fp[1] < fl[1]) && n < 500) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("drain_timeout", n < 500, 1);
  endtask
  task automatic clr_cnt();
    act_cnt = '{0, 0};
    sent_cnt = '{0, 0};
  endtask
  initial begin
    logic [7:0] pat [4] = '{8'h3C, 8'hA5, 8'h0F, 8'hF0};
    int n;
    repeat (3) tick(1'b1, 8'h77);
    resetN = 1'b1;
    clr_cnt();
    foreach (pat[i]) tick(1'b1, pat[i]);
    drain();
    check("frame_len", act_cnt[0], 92);
    check("sent_pulses", sent_cnt[0], 1);
    foreach (pat[i]) begin
      tick(1'b1, pat[i]);
      repeat (2) tick(1'b0, 8'h00);
    end
    n = 0;
    while (fp[0] < fl[0] && n < 200) begin
      tick(1'b1, 8'($urandom));
      n++;
    end
    drain();
    for (int b = 1; b <= 8; ) begin
      tick(1'b1, 8'(b));
      if (acc0) b++;
    end
    drain();
    for (int b = 0; b < 4; b++) tick(1'b1, 8'h11 * (b + 1));
    n = 0;
    while (fp[0] != 41 && n < 200) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("mid_frame_reach", n < 200, 1);
    resetN = 1'b0;
    #1;
    check("async_lanes", ln[0], 4'h0);
    check("async_active", act[0], 1'b0);
    check("async_ready", rdy[0], 1'b0);
    rst_model();
    repeat (2) tick(1'b0, 8'h00);
    resetN = 1'b1;
    repeat (4) tick(1'b1, 8'hFF);
    drain();
    repeat (400) tick(1'($urandom_range(0, 1)), 8'($urandom));
    drain();
    resetN = 1'b0;
    rst_model();
    tick(1'b0, 8'h00);
    resetN = 1'b1;
    clr_cnt();
    tick(1'b1, 8'h5A);
    drain();
    check("frame_len_small", act_cnt[1], 17);
    check("sent_pulses_small", sent_cnt[1], 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
